// File: rtl/vmem_arb_pkg.sv
// rtl/vmem_arb_pkg.sv - shared widths, grant encoding and saturating helper for the frame-buffer arbiter
package vmem_arb_pkg;

  localparam int AW_DEF = 19;
  localparam int DW_DEF = 24;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_W0,
    GNT_W1
  } gnt_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vmem_arb_wait_ctr.sv
// rtl/vmem_arb_wait_ctr.sv - per-writer starvation counter, flags urgency after MAX_WAIT stalled cycles
module vmem_arb_wait_ctr
  import vmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic valid,
  input  logic ready,
  output logic urgent
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_cnt <= '0;
    else if (!valid || ready)
      r_cnt <= '0;
    else
      r_cnt <= CW'(sat_inc(32'(r_cnt), 32'(MAX_WAIT)));
  end

  assign urgent = valid && (32'(r_cnt) == 32'(MAX_WAIT));

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - single-port frame-buffer arbiter: VGA reads first, writers round-robin,
// with a starvation guard that may steal one VGA slot and counts each steal
module vmem_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 64,
  parameter int UCW      = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           vga_req,
  input  logic [AW-1:0]  vga_addr,
  output logic           vga_gnt,
  output logic           vga_rvalid,
  output logic [DW-1:0]  vga_rdata,
  input  logic           w0_valid,
  input  logic [AW-1:0]  w0_addr,
  input  logic [DW-1:0]  w0_data,
  output logic           w0_ready,
  input  logic           w1_valid,
  input  logic [AW-1:0]  w1_addr,
  input  logic [DW-1:0]  w1_data,
  output logic           w1_ready,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_we,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic [UCW-1:0] underrun_cnt
);

  localparam logic [31:0] UMAX = 32'((64'd1 << UCW) - 64'd1);

  gnt_e           w_gnt;
  logic           w_urg0;
  logic           w_urg1;
  logic           w_preempt;
  logic           r_rr;
  logic           r_rvalid;
  logic [UCW-1:0] r_under;

  vmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
    .clk    (clk),
    .resetn (resetn),
    .valid  (w0_valid),
    .ready  (w0_ready),
    .urgent (w_urg0)
  );

  vmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
    .clk    (clk),
    .resetn (resetn),
    .valid  (w1_valid),
    .ready  (w1_ready),
    .urgent (w_urg1)
  );

  // r_rr = 1 means writer 1 wins a tie at either priority level
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_urg0 && w_urg1)
      w_gnt = r_rr ? GNT_W1 : GNT_W0;
    else if (w_urg0)
      w_gnt = GNT_W0;
    else if (w_urg1)
      w_gnt = GNT_W1;
    else if (vga_req)
      w_gnt = GNT_VGA;
    else if (w0_valid && w1_valid)
      w_gnt = r_rr ? GNT_W1 : GNT_W0;
    else if (w0_valid)
      w_gnt = GNT_W0;
    else if (w1_valid)
      w_gnt = GNT_W1;
  end

  assign w_preempt = resetn && vga_req && (w_urg0 || w_urg1);

  assign vga_gnt   = resetn && (w_gnt == GNT_VGA);
  assign w0_ready  = resetn && (w_gnt == GNT_W0);
  assign w1_ready  = resetn && (w_gnt == GNT_W1);
  assign mem_we    = w0_ready || w1_ready;
  assign mem_addr  = w0_ready ? w0_addr : (w1_ready ? w1_addr : vga_addr);
  assign mem_wdata = (w_gnt == GNT_W1) ? w1_data : w0_data;

  assign vga_rvalid   = r_rvalid;
  assign vga_rdata    = mem_rdata;
  assign underrun_cnt = r_under;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rvalid <= 1'b0;
      r_rr     <= 1'b0;
      r_under  <= '0;
    end else begin
      r_rvalid <= vga_gnt;
      if (w0_ready)
        r_rr <= 1'b1;
      else if (w1_ready)
        r_rr <= 1'b0;
      if (w_preempt)
        r_under <= UCW'(sat_inc(32'(r_under), UMAX));
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - directed and randomized checks of vmem_arbiter against a transaction-level model
module tb_vmem_arbiter;

  localparam int MW = 64;

  logic        clk;
  logic        resetn;
  logic        vga_req;
  logic [18:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [23:0] vga_rdata;
  logic        w0_valid;
  logic [18:0] w0_addr;
  logic [23:0] w0_data;
  logic        w0_ready;
  logic        w1_valid;
  logic [18:0] w1_addr;
  logic [23:0] w1_data;
  logic        w1_ready;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [15:0] underrun_cnt;

  logic        s_req;
  logic        s_w0v;
  logic        s_gnt;
  logic        s_rvalid;
  logic [23:0] s_rdata;
  logic        s_w0r;
  logic        s_w1r;
  logic [18:0] s_maddr;
  logic        s_mwe;
  logic [23:0] s_mwdata;
  logic [2:0]  s_under;

  vmem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .underrun_cnt(underrun_cnt)
  );

  // Small instance so counter saturation is reachable in a short run
  vmem_arbiter #(.MAX_WAIT(2), .UCW(3)) dut_sat (
    .clk(clk), .resetn(resetn),
    .vga_req(s_req), .vga_addr(19'h0), .vga_gnt(s_gnt),
    .vga_rvalid(s_rvalid), .vga_rdata(s_rdata),
    .w0_valid(s_w0v), .w0_addr(19'h5), .w0_data(24'h1), .w0_ready(s_w0r),
    .w1_valid(1'b0), .w1_addr(19'h0), .w1_data(24'h0), .w1_ready(s_w1r),
    .mem_addr(s_maddr), .mem_we(s_mwe), .mem_wdata(s_mwdata), .mem_rdata(24'h0),
    .underrun_cnt(s_under)
  );

  logic [23:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[9:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_wait0, m_wait1, m_pref, m_under;
  bit          m_rvalid, m_rd_known;
  logic [23:0] m_rdata;
  logic [23:0] gold [int];
  bit          obs_w0r, obs_w1r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit a, input bit b);
    if (a && b) return (m_pref == 0) ? 2 : 3;
    return a ? 2 : 3;
  endfunction

  task automatic model_reset();
    m_wait0 = 0; m_wait1 = 0; m_pref = 0; m_under = 0; m_rvalid = 0; m_rd_known = 0;
  endtask

  // Called at posedge+1 with inputs driven; checks this cycle, then advances one clock
  task automatic cycle();
    int g;
    bit u0, u1;
    logic [18:0] ea;
    #3;
    u0 = w0_valid && (m_wait0 >= MW);
    u1 = w1_valid && (m_wait1 >= MW);
    if (u0 || u1)                 g = pick(u0, u1);
    else if (vga_req)             g = 1;
    else if (w0_valid || w1_valid) g = pick(w0_valid, w1_valid);
    else                          g = 0;
    ea = (g == 2) ? w0_addr : ((g == 3) ? w1_addr : vga_addr);
    chk("vga_gnt", 32'(vga_gnt), 32'(g == 1));
    chk("w0_ready", 32'(w0_ready), 32'(g == 2));
    chk("w1_ready", 32'(w1_ready), 32'(g == 3));
    chk("mem_we", 32'(mem_we), 32'(g >= 2));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    if (g >= 2) chk("mem_wdata", 32'(mem_wdata), 32'((g == 2) ? w0_data : w1_data));
    chk("vga_rvalid", 32'(vga_rvalid), 32'(m_rvalid));
    if (m_rvalid && m_rd_known) chk("vga_rdata", 32'(vga_rdata), 32'(m_rdata));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
    obs_w0r = w0_ready;
    obs_w1r = w1_ready;
    if (g == 1) begin
      m_rd_known = gold.exists(int'(vga_addr));
      if (m_rd_known) m_rdata = gold[int'(vga_addr)];
    end
    m_rvalid = (g == 1);
    if (g == 2) begin gold[int'(w0_addr)] = w0_data; m_pref = 1; end
    if (g == 3) begin gold[int'(w1_addr)] = w1_data; m_pref = 0; end
    if (g >= 2 && (u0 || u1) && vga_req && m_under < 65535) m_under++;
    m_wait0 = (w0_valid && g != 2) ? ((m_wait0 < MW) ? m_wait0 + 1 : MW) : 0;
    m_wait1 = (w1_valid && g != 3) ? ((m_wait1 < MW) ? m_wait1 + 1 : MW) : 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits, hit_at, busy;
    resetn = 0; vga_req = 1; vga_addr = 19'h10;
    w0_valid = 0; w0_addr = 0; w0_data = 0;
    w1_valid = 0; w1_addr = 0; w1_data = 0;
    s_req = 0; s_w0v = 0;
    obs_w0r = 0; obs_w1r = 0;
    model_reset();
    #12;
    chk("rst_gnt", 32'(vga_gnt), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_rvalid", 32'(vga_rvalid), 0);
    chk("rst_under", 32'(underrun_cnt), 0);
    @(posedge clk); #1;
    vga_req = 0;
    resetn = 1;

    // Preload 0xFF0000 at 0x10 through writer 1 so rr_ptr still prefers writer 0
    w1_valid = 1; w1_addr = 19'h10; w1_data = 24'hFF0000;
    cycle();
    w1_valid = 0;

    vga_req = 1; vga_addr = 19'h10;
    for (int i = 0; i < 8; i++) cycle();
    chk("vga_stream_rdata", 32'(vga_rdata), 32'h00FF0000);

    vga_req = 0;
    w0_valid = 1; w0_addr = 19'h100; w0_data = 24'($urandom);
    w1_valid = 1; w1_addr = 19'h180; w1_data = 24'($urandom);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("alternate_w0", 32'(obs_w0r), 32'(i % 2 == 0));
      if (obs_w0r) begin w0_addr = 19'h100 + 19'(i); w0_data = 24'($urandom); end
      if (obs_w1r) begin w1_addr = 19'h180 + 19'(i); w1_data = 24'($urandom); end
    end
    w0_valid = 0; w1_valid = 0;
    cycle();

    vga_req = 1; vga_addr = 19'h10;
    w1_valid = 1; w1_addr = 19'h20; w1_data = 24'h00FF00;
    hits = 0; hit_at = 0;
    for (int i = 1; i <= 70; i++) begin
      cycle();
      if (obs_w1r) begin hits++; hit_at = i; w1_valid = 0; end
    end
    chk("starve_grants", 32'(hits), 1);
    chk("starve_cycle", 32'(hit_at), 65);
    chk("starve_under", 32'(underrun_cnt), 1);

    vga_req = 0; w0_valid = 1; w0_addr = 19'h30; w0_data = 24'h0000FF;
    cycle();
    w0_valid = 0; vga_req = 1; vga_addr = 19'h30;
    cycle();
    chk("wr_then_rd_rvalid", 32'(vga_rvalid), 1);
    chk("wr_then_rd_rdata", 32'(vga_rdata), 32'h0000FF);

    vga_req = 0;
    resetn = 0;
    #1;
    chk("midrst_rvalid", 32'(vga_rvalid), 0);
    chk("midrst_under", 32'(underrun_cnt), 0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    w0_valid = 1; w0_addr = 19'h50; w0_data = 24'h123456;
    w1_valid = 1; w1_addr = 19'h51; w1_data = 24'h654321;
    cycle();
    chk("post_rst_w0_first", 32'(obs_w0r), 1);
    w0_valid = 0; w1_valid = 0;
    obs_w0r = 0; obs_w1r = 0;

    for (int b = 0; b < 20; b++) begin
      busy = ($urandom_range(3) == 0) ? 100 : 55;
      for (int i = 0; i < 150; i++) begin
        if (!w0_valid || obs_w0r) begin
          w0_valid = ($urandom % 100) < 40;
          w0_addr = 19'h40 + 19'($urandom % 16);
          w0_data = 24'($urandom);
        end
        if (!w1_valid || obs_w1r) begin
          w1_valid = ($urandom % 100) < 40;
          w1_addr = 19'h40 + 19'($urandom % 16);
          w1_data = 24'($urandom);
        end
        vga_req = int'($urandom % 100) < busy;
        vga_addr = 19'h40 + 19'($urandom % 16);
        cycle();
      end
    end
    vga_req = 0; w0_valid = 0; w1_valid = 0;

    // MAX_WAIT=2 instance: a steal every third cycle, counter saturates at 7
    s_req = 1; s_w0v = 1;
    for (int k = 1; k <= 30; k++) begin
      #3;
      chk("sat_ready", 32'(s_w0r), 32'(k % 3 == 0));
      chk("sat_gnt", 32'(s_gnt), 32'(k % 3 != 0));
      chk("sat_under", 32'(s_under), 32'(((k - 1) / 3 < 7) ? (k - 1) / 3 : 7));
      @(posedge clk); #1;
    end
    s_req = 0; s_w0v = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
